// File: rtl/sprite_draw_engine_if.sv
// Sprite command / pixel byte input and framebuffer write port of the sprite draw engine.
// The engine takes the slave side; the decoder/framebuffer environment takes the master side.
interface sprite_draw_engine_if;
    logic        sprite_enable_in;
    logic        data_valid_in;
    logic [7:0]  sprite_data_in;
    logic [9:0]  sprite_x_position_in;
    logic [9:0]  sprite_y_position_in;
    logic [9:0]  sprite_width_in;
    logic [4:0]  sprite_total_colors_in;
    logic [3:0]  sprite_palette_offset_in;
    logic        pixel_ready_in;
    logic        pixel_write_enable_out;
    logic [17:0] pixel_address_out;
    logic [3:0]  pixel_color_out;
    logic        busy_out;
    logic        overflow_out;

    modport master (
        output sprite_enable_in, data_valid_in, sprite_data_in,
               sprite_x_position_in, sprite_y_position_in, sprite_width_in,
               sprite_total_colors_in, sprite_palette_offset_in, pixel_ready_in,
        input  pixel_write_enable_out, pixel_address_out, pixel_color_out,
               busy_out, overflow_out
    );

    modport slave (
        input  sprite_enable_in, data_valid_in, sprite_data_in,
               sprite_x_position_in, sprite_y_position_in, sprite_width_in,
               sprite_total_colors_in, sprite_palette_offset_in, pixel_ready_in,
        output pixel_write_enable_out, pixel_address_out, pixel_color_out,
               busy_out, overflow_out
    );
endinterface

// File: rtl/sprite_draw_engine.sv
// Sprite draw engine: buffers pixel bytes, unpacks them at 1/2/4 bpp and emits
// clipped, palette-offset framebuffer writes along a wrapping raster cursor.
module sprite_draw_engine #(
    parameter int FIFO_DEPTH    = 8,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 400
) (
    input logic                 clock_in,
    input logic                 reset_n_in,
    sprite_draw_engine_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] width;
        logic [4:0] colors;
        logic [3:0] offset;
    } sprite_params_t;

    typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;

    function automatic logic [2:0] bpp_of(input logic [4:0] colors);
        if (colors <= 5'd2)      return 3'd1;
        else if (colors <= 5'd4) return 3'd2;
        else                     return 3'd4;
    endfunction

    // Input edge detection and byte tagging
    logic dv_q, en_q, first_flag;
    logic dv_rise, en_rise, push, push_ok, pop, tag;

    // Byte FIFO
    logic [8:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic        fifo_empty, fifo_full;
    logic [8:0]  fifo_q;
    logic        overflow;

    // Unpacker
    state_t         state;
    sprite_params_t pend;
    logic [9:0]     act_x, act_width;
    logic [3:0]     act_offset;
    logic [2:0]     bpp, bpp_ld;
    logic [7:0]     sh;
    logic           load_first;
    logic [3:0]     pix_cnt;
    logic [10:0]    cx, cy, cx_inc;
    logic           we_q;
    logic [17:0]    addr_q;
    logic [3:0]     color_q;
    logic           stall, last_pix, wrap, in_screen, do_write;
    logic [3:0]     v;
    logic [17:0]    addr_n;

    assign dv_rise    = bus.data_valid_in & ~dv_q;
    assign en_rise    = bus.sprite_enable_in & ~en_q;
    assign push       = dv_rise & bus.sprite_enable_in;
    assign tag        = first_flag | en_rise;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
    assign fifo_q     = mem[rd_ptr];
    assign stall      = we_q & ~bus.pixel_ready_in;
    assign last_pix   = (pix_cnt == 4'd1);
    assign pop        = !stall && !fifo_empty && (state == IDLE || (state == EMIT && last_pix));
    assign push_ok    = push && (!fifo_full || pop);
    assign bpp_ld     = load_first ? bpp_of(pend.colors) : bpp;

    always_comb begin
        v = 4'd0;
        case (bpp)
            3'd1:    v = {3'b000, sh[7]};
            3'd2:    v = {2'b00, sh[7:6]};
            default: v = sh[7:4];
        endcase
        cx_inc    = cx + 11'd1;
        // A zero width never wraps and never draws
        wrap      = (act_width != 10'd0) && ((cx_inc - {1'b0, act_x}) == {1'b0, act_width});
        in_screen = (cx < 11'(SCREEN_WIDTH)) && (cy < 11'(SCREEN_HEIGHT));
        do_write  = (v != 4'd0) && in_screen && (act_width != 10'd0);
        addr_n    = 18'(cy) * 18'(SCREEN_WIDTH) + 18'(cx);
    end

    always_ff @(posedge clock_in) begin
        if (push_ok) mem[wr_ptr] <= {tag, bus.sprite_data_in};
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            dv_q       <= 1'b0;
            en_q       <= 1'b0;
            first_flag <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            pend       <= '0;
        end else begin
            dv_q <= bus.data_valid_in;
            en_q <= bus.sprite_enable_in;
            if (push)         first_flag <= 1'b0;
            else if (en_rise) first_flag <= 1'b1;
            if (en_rise) begin
                pend <= '{x: bus.sprite_x_position_in, y: bus.sprite_y_position_in,
                          width: bus.sprite_width_in, colors: bus.sprite_total_colors_in,
                          offset: bus.sprite_palette_offset_in};
            end
            if (push && !push_ok) overflow <= 1'b1;
            else if (en_rise)     overflow <= 1'b0;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
        end
    end

    // Unpacker FSM; a stalled write freezes the whole FSM and its outputs
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state      <= IDLE;
            sh         <= '0;
            load_first <= 1'b0;
            pix_cnt    <= '0;
            bpp        <= 3'd1;
            act_x      <= '0;
            act_width  <= '0;
            act_offset <= '0;
            cx         <= '0;
            cy         <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            color_q    <= '0;
        end else if (!stall) begin
            we_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        sh         <= fifo_q[7:0];
                        load_first <= fifo_q[8];
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    if (load_first) begin
                        act_x      <= pend.x;
                        act_width  <= pend.width;
                        act_offset <= pend.offset;
                        cx         <= {1'b0, pend.x};
                        cy         <= {1'b0, pend.y};
                    end
                    bpp <= bpp_ld;
                    case (bpp_ld)
                        3'd1:    pix_cnt <= 4'd8;
                        3'd2:    pix_cnt <= 4'd4;
                        default: pix_cnt <= 4'd2;
                    endcase
                    state <= EMIT;
                end
                EMIT: begin
                    we_q    <= do_write;
                    addr_q  <= addr_n;
                    color_q <= v + act_offset;
                    sh      <= sh << bpp;
                    pix_cnt <= pix_cnt - 4'd1;
                    if (wrap) begin
                        cx <= {1'b0, act_x};
                        cy <= cy + 11'd1;
                    end else begin
                        cx <= cx_inc;
                    end
                    if (last_pix) begin
                        if (pop) begin
                            sh         <= fifo_q[7:0];
                            load_first <= fifo_q[8];
                            state      <= LOAD;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.pixel_write_enable_out = we_q;
    assign bus.pixel_address_out      = addr_q;
    assign bus.pixel_color_out        = color_q;
    assign bus.busy_out               = !fifo_empty || (state != IDLE);
    assign bus.overflow_out           = overflow;
endmodule
